// File: rtl/neuron_feeder_pkg.sv
// Shared types and default sizing for the neuron feeder and its address generator.
package neuron_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  localparam int DEF_IN_WIDTH    = 16;
  localparam int DEF_NUM_INPUTS  = 784;
  localparam int DEF_NUM_NEURONS = 10;
  localparam int DEF_DADDR_WIDTH = 10;
  localparam int DEF_WADDR_WIDTH = 13;
  localparam int DEF_BADDR_WIDTH = 4;

endpackage

// File: rtl/neuron_feeder_addr_gen.sv
// Element / pass / weight-address counters for the neuron feeder; advance once per issued read.
module neuron_feeder_addr_gen
  import neuron_feeder_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int DADDR_WIDTH = DEF_DADDR_WIDTH,
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int BADDR_WIDTH = DEF_BADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   issue,
  output logic [DADDR_WIDTH-1:0] elem,
  output logic [WADDR_WIDTH-1:0] waddr,
  output logic [BADDR_WIDTH-1:0] pass,
  output logic                   last_elem,
  output logic                   last_pass
);

  logic [DADDR_WIDTH-1:0] elem_r;
  logic [WADDR_WIDTH-1:0] waddr_r;
  logic [BADDR_WIDTH-1:0] pass_r;

  assign last_elem = (elem_r == DADDR_WIDTH'(NUM_INPUTS - 1));
  assign last_pass = (pass_r == BADDR_WIDTH'(NUM_NEURONS - 1));

  // counters; waddr runs on across passes, pass stays on the final pass once the frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_r  <= '0;
      waddr_r <= '0;
      pass_r  <= '0;
    end else if (clear) begin
      elem_r  <= '0;
      waddr_r <= '0;
      pass_r  <= '0;
    end else if (issue) begin
      waddr_r <= waddr_r + WADDR_WIDTH'(1);
      if (last_elem) begin
        elem_r <= '0;
        if (!last_pass) begin
          pass_r <= pass_r + BADDR_WIDTH'(1);
        end else begin
          pass_r <= pass_r;
        end
      end else begin
        elem_r <= elem_r + DADDR_WIDTH'(1);
      end
    end
  end

  assign elem  = elem_r;
  assign waddr = waddr_r;
  assign pass  = pass_r;

endmodule

// File: rtl/neuron_feeder.sv
// Upstream sequencer for the serial MAC neuron: streams pixel/weight pairs and per-pass bias.
// Build option NEURON_FEEDER_GAP_EN inserts one bubble slot between consecutive passes.
module neuron_feeder
  import neuron_feeder_pkg::*;
#(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int DADDR_WIDTH = DEF_DADDR_WIDTH,
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int BADDR_WIDTH = DEF_BADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stall,
  output logic [DADDR_WIDTH-1:0] data_addr,
  output logic [WADDR_WIDTH-1:0] weight_addr,
  output logic [BADDR_WIDTH-1:0] bias_addr,
  input  logic [IN_WIDTH-1:0]    data_rd,
  input  logic [IN_WIDTH-1:0]    weight_rd,
  input  logic [IN_WIDTH-1:0]    bias_rd,
  output logic [IN_WIDTH-1:0]    data_out,
  output logic [IN_WIDTH-1:0]    weight_out,
  output logic [IN_WIDTH-1:0]    bias_out,
  output logic                   out_valid,
  input  logic                   res_valid,
  output logic                   busy,
  output logic                   done,
  output logic [BADDR_WIDTH-1:0] pass_idx
);

  localparam logic [BADDR_WIDTH:0] RES_TARGET = (BADDR_WIDTH + 1)'(NUM_NEURONS);

  feeder_state_t state_r, state_nx_s;

  logic                   clear_s, issue_s, adv_s, frame_end_s, gap_s, res_inc_s;
  logic                   last_elem_s, last_pass_s;
  logic [DADDR_WIDTH-1:0] elem_s;
  logic [WADDR_WIDTH-1:0] waddr_s;
  logic [BADDR_WIDTH-1:0] pass_s;
  logic [BADDR_WIDTH:0]   res_cnt_r, res_cnt_nx_s;
  logic                   busy_r, done_r;
  logic                   issue_d_r, first_d_r, rd_vld_r, rd_first_r, out_valid_r;
  logic [DADDR_WIDTH-1:0] data_addr_r;
  logic [WADDR_WIDTH-1:0] weight_addr_r;
  logic [BADDR_WIDTH-1:0] bias_addr_r;
  logic [IN_WIDTH-1:0]    data_out_r, weight_out_r, bias_out_r;

  assign clear_s      = (state_r == IDLE) && start;
  assign issue_s      = (state_r == RUN) && !stall && !gap_s;
  assign adv_s        = issue_s && last_elem_s && !last_pass_s;
  assign frame_end_s  = issue_s && last_elem_s && last_pass_s;
  assign res_inc_s    = busy_r && res_valid;
  assign res_cnt_nx_s = res_cnt_r + {{BADDR_WIDTH{1'b0}}, res_inc_s};

  neuron_feeder_addr_gen #(
    .NUM_INPUTS  (NUM_INPUTS),
    .NUM_NEURONS (NUM_NEURONS),
    .DADDR_WIDTH (DADDR_WIDTH),
    .WADDR_WIDTH (WADDR_WIDTH),
    .BADDR_WIDTH (BADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_s),
    .issue     (issue_s),
    .elem      (elem_s),
    .waddr     (waddr_s),
    .pass      (pass_s),
    .last_elem (last_elem_s),
    .last_pass (last_pass_s)
  );

`ifdef NEURON_FEEDER_GAP_EN
  logic gap_r;

  // bubble slot after each pass boundary; a stalled cycle does not use it up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_r <= 1'b0;
    end else if (clear_s) begin
      gap_r <= 1'b0;
    end else if (adv_s) begin
      gap_r <= 1'b1;
    end else if ((state_r == RUN) && !stall) begin
      gap_r <= 1'b0;
    end
  end

  assign gap_s = gap_r;
`else
  assign gap_s = 1'b0;
`endif

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = RUN;
        else       state_nx_s = IDLE;
      end
      RUN: begin
        if (frame_end_s) state_nx_s = DRAIN;
        else             state_nx_s = RUN;
      end
      DRAIN: begin
        if (res_cnt_nx_s >= RES_TARGET) state_nx_s = DONE;
        else                            state_nx_s = DRAIN;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // state, frame status and result counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      res_cnt_r <= '0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == RUN) || (state_nx_s == DRAIN);
      done_r  <= (state_nx_s == DONE);
      if (clear_s) res_cnt_r <= '0;
      else         res_cnt_r <= res_cnt_nx_s;
    end
  end

  // read issue: address registers plus issue -> read-data valid pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_addr_r   <= '0;
      weight_addr_r <= '0;
      bias_addr_r   <= '0;
      issue_d_r     <= 1'b0;
      first_d_r     <= 1'b0;
      rd_vld_r      <= 1'b0;
      rd_first_r    <= 1'b0;
    end else begin
      if (clear_s) begin
        data_addr_r   <= '0;
        weight_addr_r <= '0;
        bias_addr_r   <= '0;
      end else if (issue_s) begin
        data_addr_r   <= elem_s;
        weight_addr_r <= waddr_s;
        if (adv_s) bias_addr_r <= pass_s + BADDR_WIDTH'(1);
      end
      issue_d_r  <= issue_s;
      first_d_r  <= issue_s && (elem_s == '0);
      rd_vld_r   <= issue_d_r;
      rd_first_r <= first_d_r;
    end
  end

  // presentation registers; bias is taken alongside the first pair of each pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      data_out_r   <= '0;
      weight_out_r <= '0;
      bias_out_r   <= '0;
    end else begin
      out_valid_r <= rd_vld_r;
      if (rd_vld_r) begin
        data_out_r   <= data_rd;
        weight_out_r <= weight_rd;
      end
      if (rd_first_r) bias_out_r <= bias_rd;
    end
  end

  assign data_addr   = data_addr_r;
  assign weight_addr = weight_addr_r;
  assign bias_addr   = bias_addr_r;
  assign data_out    = data_out_r;
  assign weight_out  = weight_out_r;
  assign bias_out    = bias_out_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass_idx    = pass_s;

endmodule

// File: tb/tb_neuron_feeder.sv
// Self-checking bench for neuron_feeder: queue-based presentation model plus frame-level checks.
module tb_neuron_feeder;

  localparam int NI = 4;
  localparam int NN = 2;
  localparam int IW = 16;
  localparam int DW = 10;
  localparam int WW = 13;
  localparam int BW = 4;
`ifdef NEURON_FEEDER_GAP_EN
  localparam int GAPS = NN - 1;
`else
  localparam int GAPS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, stall, res_valid;
  logic [DW-1:0] data_addr;
  logic [WW-1:0] weight_addr;
  logic [BW-1:0] bias_addr, pass_idx;
  logic [IW-1:0] data_rd, weight_rd, bias_rd;
  logic [IW-1:0] data_out, weight_out, bias_out;
  logic          out_valid, busy, done;

  always #5 clk = ~clk;

  neuron_feeder #(
    .IN_WIDTH(IW), .NUM_INPUTS(NI), .NUM_NEURONS(NN),
    .DADDR_WIDTH(DW), .WADDR_WIDTH(WW), .BADDR_WIDTH(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .data_addr(data_addr), .weight_addr(weight_addr), .bias_addr(bias_addr),
    .data_rd(data_rd), .weight_rd(weight_rd), .bias_rd(bias_rd),
    .data_out(data_out), .weight_out(weight_out), .bias_out(bias_out),
    .out_valid(out_valid), .res_valid(res_valid), .busy(busy), .done(done),
    .pass_idx(pass_idx)
  );

  // synchronous memories with one cycle of read latency
  always @(posedge clk) begin
    data_rd   <= IW'(data_addr) + 16'd1;
    weight_rd <= 16'h8000 | (IW'(weight_addr) + 16'd1);
    bias_rd   <= IW'(bias_addr) + 16'd1;
  end

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] w;
    logic [15:0] b;
  } pres_t;

  pres_t       exp_q[$];
  int          total = 0, bad = 0, cyc = 0;
  bit          m_busy = 1'b0;
  int          rcnt = 0, exp_done = -1;
  int          fov = 0, idle = 0, idle_run = 0, brk = -1, dones = 0;
  logic [15:0] hd[8], hw[8], hb[8];
  int          stall_left = 0, stall_at = -1;
  bit          stall_rnd = 1'b0, stall_fired = 1'b0;
  logic        n_start = 1'b0, n_res = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ctl"},  32'({out_valid, busy, done, bias_out}), 32'd0);
    chk({pfx, "_data"}, 32'({data_out, weight_out}), 32'd0);
    chk({pfx, "_addr"}, 32'({data_addr, weight_addr, bias_addr, pass_idx}), 32'd0);
  endtask

  // per-cycle compare against the frame model, then advance the model with this cycle's inputs
  task automatic sample();
    pres_t p;
    if (!rst_n) begin
      chk_zero("rst");
      exp_q.delete();
      m_busy   = 1'b0;
      rcnt     = 0;
      exp_done = -1;
      return;
    end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(cyc == exp_done));
    if (done) dones++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        p = exp_q.pop_front();
        chk("data_out",   32'(data_out),   32'(p.d));
        chk("weight_out", 32'(weight_out), 32'(p.w));
        chk("bias_out",   32'(bias_out),   32'(p.b));
        if (fov < 8) begin
          hd[fov] = data_out;
          hw[fov] = weight_out;
          hb[fov] = bias_out;
        end
        if (idle_run > 0 && brk < 0) brk = fov;
        idle     += idle_run;
        idle_run = 0;
        fov++;
        if (fov == stall_at && !stall_fired) begin
          stall_left  = 3;
          stall_fired = 1'b1;
        end
      end
    end else if (fov > 0 && exp_q.size() > 0) begin
      idle_run++;
    end
    if (m_busy && res_valid) begin
      rcnt++;
      if (rcnt == NN) begin
        m_busy   = 1'b0;
        exp_done = cyc + 1;
      end
    end else if (!m_busy && cyc != exp_done && start) begin
      m_busy   = 1'b1;
      rcnt     = 0;
      fov      = 0;
      idle     = 0;
      idle_run = 0;
      brk      = -1;
      for (int pp = 0; pp < NN; pp++)
        for (int e = 0; e < NI; e++)
          exp_q.push_back('{d: 16'(e + 1), w: 16'h8000 | 16'(pp * NI + e + 1), b: 16'(pp + 1)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start     = n_start;
    res_valid = n_res;
    n_start   = 1'b0;
    n_res     = 1'b0;
    if (stall_left > 0) begin
      stall = 1'b1;
      stall_left--;
    end else begin
      stall = stall_rnd && ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic wait_fov(input int n, input string what);
    int k = 0;
    while (fov < n && k < 200) begin
      tick();
      k++;
    end
    chk({"reach_", what}, 32'(fov >= n), 32'd1);
  endtask

  task automatic run_frame(input int stall_pos, input bit rnd, input bit restart, input int exp_idle);
    int k = 0;
    dones       = 0;
    stall_at    = stall_pos;
    stall_fired = 1'b0;
    stall_rnd   = rnd;
    n_start     = 1'b1;
    tick();
    for (int p = 0; p < NN; p++) begin
      if (restart && p == 0) begin
        wait_fov(2, "restart_point");
        n_start = 1'b1;
        tick();
      end
      wait_fov((p + 1) * NI, "pass_end");
      repeat ($urandom_range(0, 2)) tick();
      n_res = 1'b1;
      tick();
    end
    while (dones == 0 && k < 20) begin
      tick();
      k++;
    end
    stall_rnd = 1'b0;
    repeat (2) tick();
    chk("frame_valids", 32'(fov), 32'(NN * NI));
    chk("frame_dones", 32'(dones), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    if (exp_idle >= 0) chk("idle_cycles", 32'(idle), 32'(exp_idle));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    res_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_zero("reset_state");

    // plain frame, then hand-computed pins on the recorded presentations
    run_frame(-1, 1'b0, 1'b0, GAPS);
    chk("pin_d0", 32'(hd[0]), 32'h1);
    chk("pin_d3", 32'(hd[3]), 32'h4);
    chk("pin_d4", 32'(hd[4]), 32'h1);
    chk("pin_w0", 32'(hw[0]), 32'h8001);
    chk("pin_w7", 32'(hw[7]), 32'h8008);
    chk("pin_b0", 32'(hb[0]), 32'h1);
    chk("pin_b4", 32'(hb[4]), 32'h2);
`ifdef NEURON_FEEDER_GAP_EN
    chk("gap_position", 32'(brk), 32'd4);
`endif

    // three-cycle stall mid-pass
    run_frame(2, 1'b0, 1'b0, 3 + GAPS);

    // start pulsed while running
    run_frame(-1, 1'b0, 1'b1, GAPS);

    // asynchronous reset mid-frame, then a clean frame from address 0
    n_start = 1'b1;
    tick();
    wait_fov(5, "rst_point");
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_frame(-1, 1'b0, 1'b0, GAPS);

    // result pulses while idle must not count toward the next frame
    repeat (3) begin
      n_res = 1'b1;
      tick();
      tick();
    end
    run_frame(-1, 1'b0, 1'b0, GAPS);

    // randomized stalls and result latencies
    for (int i = 0; i < 6; i++) run_frame(-1, 1'b1, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
